// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - multi-word adder sequenced through one 4-bit ripple slice

module nibble_add_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c_msb
);

    always_comb begin
        logic [4:0] c;
        c    = '0;
        c[0] = ci;
        s    = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co    = c[4];
        c_msb = c[3];
    end

endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] x,
    input  logic [4*NIBBLES-1:0] y,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 overflow
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    x_reg;
    logic [W-1:0]    y_reg;
    logic [W-1:0]    work;
    logic [W-1:0]    work_next;
    logic            carry_reg;
    logic [IW-1:0]   idx;
    logic [IW+1:0]   base;
    logic [3:0]      slice_s;
    logic            slice_co;
    logic            slice_c3;

    assign base = {idx, 2'b00};

    nibble_add_slice u_slice (
        .a     (x_reg[base +: 4]),
        .b     (y_reg[base +: 4]),
        .ci    (carry_reg),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c3)
    );

    // The final nibble lands in work on the same edge sum is loaded, so sum
    // takes the merged value rather than the stale work register.
    always_comb begin
        work_next             = work;
        work_next[base +: 4]  = slice_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            work      <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_reg     <= x;
                        y_reg     <= y;
                        carry_reg <= c_in;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work      <= work_next;
                    carry_reg <= slice_co;
                    idx       <= idx + 1'b1;
                    if (idx == LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= work_next;
                        c_out    <= slice_co;
                        overflow <= slice_c3 ^ slice_co;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - self-checking bench for nibble_add_seq at NIBBLES 1, 4 and 8

module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cin;
    logic [31:0] xa;
    logic [31:0] ya;

    always #5 clk = ~clk;

    logic        busy1, done1, co1, ov1;
    logic [3:0]  sum1;
    logic        busy4, done4, co4, ov4;
    logic [15:0] sum4;
    logic        busy8, done8, co8, ov8;
    logic [31:0] sum8;

    nibble_add_seq #(.NIBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .x(xa[3:0]), .y(ya[3:0]), .c_in(cin),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(co1), .overflow(ov1)
    );
    nibble_add_seq #(.NIBBLES(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .x(xa[15:0]), .y(ya[15:0]), .c_in(cin),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(co4), .overflow(ov4)
    );
    nibble_add_seq #(.NIBBLES(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .x(xa), .y(ya), .c_in(cin),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8), .overflow(ov8)
    );

    logic        busy_a [3];
    logic        done_a [3];
    logic        co_a   [3];
    logic        ov_a   [3];
    logic [31:0] sum_a  [3];
    int          ns     [3];

    assign busy_a[0] = busy1;  assign busy_a[1] = busy4;  assign busy_a[2] = busy8;
    assign done_a[0] = done1;  assign done_a[1] = done4;  assign done_a[2] = done8;
    assign co_a[0]   = co1;    assign co_a[1]   = co4;    assign co_a[2]   = co8;
    assign ov_a[0]   = ov1;    assign ov_a[1]   = ov4;    assign ov_a[2]   = ov8;
    assign sum_a[0]  = {28'b0, sum1};
    assign sum_a[1]  = {16'b0, sum4};
    assign sum_a[2]  = sum8;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } res_t;

    // Reference: plain wide arithmetic plus two's-complement sign rule.
    function automatic res_t ref_add(input int n, input logic [31:0] x, input logic [31:0] y,
                                     input logic ci);
        res_t        r;
        logic [63:0] m, t, s64;
        int          w;
        w    = 4 * n;
        m    = (64'd1 << w) - 64'd1;
        t    = ({32'b0, x} & m) + ({32'b0, y} & m) + {63'b0, ci};
        s64  = t & m;
        r.s  = s64[31:0];
        r.co = t[w];
        r.ov = (x[w-1] == y[w-1]) && (s64[w-1] != x[w-1]);
        return r;
    endfunction

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[6];

    task automatic pulse_start4(input logic [15:0] x, input logic [15:0] y, input logic ci);
        @(negedge clk);
        xa    = {16'h0, x};
        ya    = {16'h0, y};
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done4(input int k0, output int k, output int bc);
        k  = k0;
        bc = 0;
        while (!done4 && k < 20) begin
            if (busy4) bc++;
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int   k, bc, cnt;
        res_t r;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        cin   = 1'b0;
        xa    = '0;
        ya    = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_busy%0d", d), busy_a[d], 0);
            check($sformatf("rst_done%0d", d), done_a[d], 0);
            check($sformatf("rst_sum%0d", d), {sum_a[d], co_a[d], ov_a[d]}, 0);
        end
        reset = 1'b0;

        foreach (vecs[i]) begin
            pulse_start4(vecs[i].x, vecs[i].y, vecs[i].ci);
            wait_done4(0, k, bc);
            check($sformatf("vec%0d_latency", i), k, 4);
            check($sformatf("vec%0d_busy_cycles", i), bc, 4);
            check($sformatf("vec%0d_busy_at_done", i), busy4, 0);
            check($sformatf("vec%0d_sum", i), {co4, sum4}, {vecs[i].co, vecs[i].s});
            check($sformatf("vec%0d_ovf", i), ov4, vecs[i].ov);
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), done4, 0);
            check($sformatf("vec%0d_sum_held", i), sum4, vecs[i].s);
        end

        // start during RUN is ignored; start in DONE is accepted back-to-back
        pulse_start4(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        xa    = 32'h0000AAAA;
        ya    = 32'h00005555;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done4(2, k, bc);
        check("ignored_start_latency", k, 4);
        check("ignored_start_sum", {co4, sum4}, 17'h00100);
        xa    = 32'h00001234;
        ya    = 32'h00004321;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy4, 1);
        check("b2b_sum_stable", sum4, 16'h0100);
        wait_done4(0, k, bc);
        check("b2b_latency", k, 4);
        check("b2b_sum", {co4, sum4}, 17'h05555);
        @(negedge clk);

        // reset in the second RUN cycle aborts without a done pulse
        pulse_start4(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_outputs", {sum4, co4, ov4}, 0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) cnt++;
        end
        check("abort_no_done", cnt, 0);

        // reset wins over a simultaneous start
        @(negedge clk);
        xa    = 32'h00000001;
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("reset_over_start", busy4, 0);

        pulse_start4(16'h7FFF, 16'h0001, 1'b0);
        wait_done4(0, k, bc);
        check("post_abort_latency", k, 4);
        check("post_abort_sum", {ov4, co4, sum4}, 18'h28000);

        repeat (20) @(negedge clk);

        for (int it = 0; it < 340; it++) begin
            logic [31:0] rx, ry;
            logic        rc;
            int          lat    [3];
            int          pulses [3];
            logic [31:0] gs     [3];
            logic        gco    [3];
            logic        gov    [3];
            rx = $urandom;
            ry = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (it % 17 == 0) ry = ~rx;
            @(negedge clk);
            xa    = rx;
            ya    = ry;
            cin   = rc;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int d = 0; d < 3; d++) begin
                lat[d] = -1; pulses[d] = 0; gs[d] = '0; gco[d] = 1'b0; gov[d] = 1'b0;
            end
            for (int kk = 0; kk < 12; kk++) begin
                for (int d = 0; d < 3; d++) begin
                    if (done_a[d]) begin
                        pulses[d]++;
                        if (lat[d] < 0) begin
                            lat[d] = kk;
                            gs[d]  = sum_a[d];
                            gco[d] = co_a[d];
                            gov[d] = ov_a[d];
                        end
                    end
                end
                @(negedge clk);
            end
            for (int d = 0; d < 3; d++) begin
                r = ref_add(ns[d], rx, ry, rc);
                check($sformatf("rnd%0d_n%0d_latency", it, ns[d]), lat[d], ns[d]);
                check($sformatf("rnd%0d_n%0d_pulses", it, ns[d]), pulses[d], 1);
                check($sformatf("rnd%0d_n%0d_sum", it, ns[d]), {gco[d], gs[d]}, {r.co, r.s});
                check($sformatf("rnd%0d_n%0d_ovf", it, ns[d]), gov[d], r.ov);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        ns[0] = 1;
        ns[1] = 4;
        ns[2] = 8;
    end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Multi-word add sequencer that produces a wide sum with one 4-bit ripple add slice.
- The slice is the same full-adder chain our 4-bit parallel adder uses.
- It adds one nibble per clock and carries through a registered carry bit.
- It sits directly upstream of the slice as its operand/carry feeder and collects the slice outputs into a registered wide result with a start/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only while busy=0.
- x  input  W  operand A; sampled on the accepted start.
- y  input  W  operand B; sampled on the accepted start.
- c_in  input  1  carry into nibble 0; sampled on the accepted start.
- busy  output  1  high while an add is in progress (RUN state).
- done  output  1  one-cycle pulse when sum/c_out/overflow become valid.
- sum  output  W  registered result; held until the next completion.
- c_out  output  1  carry out of the MSB of nibble NIBBLES-1.
- overflow  output  1  signed overflow: carry into the MSB XOR c_out.

Behaviour:
- Clock and reset: single clock domain, reset synchronous active-high.
- Reset values:
  - State = IDLE.
  - busy=0, done=0.
  - sum=0, c_out=0, overflow=0.
  - Internal operand registers, carry register and nibble index = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches x, y and c_in into operand and carry registers.
  - Sets idx=0 and goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - busy=1.
  - Each cycle the slice adds x_reg[4*idx+3:4*idx] + y_reg[same] + carry_reg.
  - The 4-bit slice sum is written into the work register at nibble idx.
  - carry_reg takes the slice carry-out; idx increments.
  - When idx = NIBBLES-1, the carry into slice bit 3 is also captured for overflow, and the next state is DONE.
  - start is ignored while in RUN; operands in flight are never disturbed.
- DONE:
  - Lasts one cycle; done=1, busy=0.
  - sum, c_out and overflow are updated from the work and carry registers on the RUN->DONE edge, so they are valid in the same cycle done is high.
  - start=1 in DONE is accepted exactly as in IDLE and goes to RUN (back-to-back operation); otherwise the next state is IDLE.
- Latency: start accepted at edge T gives done=1 in the cycle after edge T+NIBBLES; that is, NIBBLES+1 cycles from the start edge to the done cycle.
- Throughput: one add per NIBBLES+1 cycles with back-to-back starts.
- Output stability:
  - sum, c_out and overflow change only on a RUN->DONE edge or on reset.
  - Partial nibbles are never visible on sum.
- Arithmetic: unsigned {c_out, sum} = x + y + c_in, modulo 2^(W+1); no saturation.
- Reset mid-operation: aborts immediately to IDLE with all outputs at reset values; there is no done pulse for the aborted add.
- reset and start high together: reset wins; start is not accepted.
- NIBBLES=1: RUN lasts one cycle; latency is 2 cycles.

Test Plan:
- NIBBLES=4: x=0x0000, y=0x0000, c_in=0, start pulse -> after 5 cycles done=1 for exactly one cycle; sum=0x0000, c_out=0, overflow=0; busy high for 4 cycles.
- x=0x00FF, y=0x0001, c_in=0 -> sum=0x0100, c_out=0, overflow=0 (carry ripples across the nibble boundary via carry_reg).
- x=0xFFFF, y=0x0000, c_in=1 -> sum=0x0000, c_out=1, overflow=0. Then x=0x7FFF, y=0x0001, c_in=0 -> sum=0x8000, c_out=0, overflow=1.
- start pulsed again 2 cycles after an accepted start with different operands -> ignored; the first result is unchanged. start held high in the DONE cycle with x=0x1234, y=0x4321 -> second done exactly 5 cycles later with sum=0x5555.
- reset asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, state IDLE; no done pulse follows. A fresh start after reset completes normally.
- Random regression: 1000 random x/y/c_in across NIBBLES=1, 4 and 8. Compare {c_out, sum} with the reference sum x+y+c_in, and check overflow against sign-bit logic.
